control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 51 +++++
 rtl/control_unit_main_decoder.sv | 29 ++
 rtl/control_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
// Holds the opcode constants, the FSM state encoding, the RF write-back
// source encodings and the one-hot instruction class produced by the
// main decoder.
package control_unit_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned RF_SEL_W = 2;

    // Opcodes recognised by the decoder
    localparam logic [OPCODE_W-1:0] OP_R_TYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I_ALU  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

    // Register-file write-back source select
    localparam logic [RF_SEL_W-1:0] RF_SEL_MEM    = 2'b00;
    localparam logic [RF_SEL_W-1:0] RF_SEL_ULA    = 2'b01;
    localparam logic [RF_SEL_W-1:0] RF_SEL_PC4    = 2'b10;
    localparam logic [RF_SEL_W-1:0] RF_SEL_PC_IMM = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // One-hot instruction class; exactly one field is set for any opcode
    typedef struct packed {
        logic r_type;
        logic i_alu;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic auipc;
        logic system;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/control_unit_main_decoder.sv
// Opcode classifier for the control unit.
// Ports:
//   opcode  - instruction[6:0]
//   cls     - one-hot instruction class; unlisted opcodes map to 'illegal'
module main_decoder
    import control_unit_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_t        cls
);

    // Pure decode: one class bit per listed opcode, everything else illegal
    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_R_TYPE: cls.r_type  = 1'b1;
            OP_I_ALU:  cls.i_alu   = 1'b1;
            OP_LOAD:   cls.load    = 1'b1;
            OP_STORE:  cls.store   = 1'b1;
            OP_BRANCH: cls.branch  = 1'b1;
            OP_JAL:    cls.jal     = 1'b1;
            OP_JALR:   cls.jalr    = 1'b1;
            OP_AUIPC:  cls.auipc   = 1'b1;
            OP_SYSTEM: cls.system  = 1'b1;
            default:   cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer that
// drives the datapath selects and write enables from the current state and
// the instruction register (Moore plus decode).
// Ports:
//   CLK, RST      - clock and synchronous active-high reset
//   run           - advance out of FETCH when high
//   instruction   - instruction register contents
//   sub, WE_RF, WE_MEM, ULA_din2_sel, load_pc, reset_pc,
//   pc_next_sel, pc_adder_sel, RF_din_sel - datapath controls
//   instr_done    - high in the last state of each instruction
//   halted        - high while in HALT
//   state         - current FSM state (debug)
// Build option:
//   CONTROL_ILLEGAL_TRAP_EN - when defined, unlisted opcodes halt the core;
//                             otherwise they execute as a 3-cycle NOP.
module control_unit
    import control_unit_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                run,
    input  logic [31:0]         instruction,
    output logic                sub,
    output logic                WE_RF,
    output logic                WE_MEM,
    output logic                ULA_din2_sel,
    output logic                load_pc,
    output logic                reset_pc,
    output logic                pc_next_sel,
    output logic                pc_adder_sel,
    output logic [RF_SEL_W-1:0] RF_din_sel,
    output logic                instr_done,
    output logic                halted,
    output logic [STATE_W-1:0]  state
);

    state_t       cur_state;
    instr_class_t cls;

    logic [2:0] funct3;
    logic       funct7_b5;
    logic       alu_sub;
    logic       has_wb;
    logic       has_mem;
    logic       is_jump;
    logic       last;

    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];

    // Register indices and immediates are consumed by the datapath only
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instruction[31], instruction[29:15],
                                 instruction[11:7]};

    main_decoder u_main_decoder (
        .opcode (instruction[OPCODE_W-1:0]),
        .cls    (cls)
    );

    // ADD/SUB is the only funct3=000 op where bit 30 selects subtraction
    assign alu_sub = cls.r_type && (funct3 == 3'b000) && funct7_b5;
    assign has_wb  = cls.r_type || cls.i_alu || cls.auipc || cls.load;
    assign has_mem = cls.load || cls.store;
    assign is_jump = cls.branch || cls.jal || cls.jalr;

    // State sequencing
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= FETCH;
        end else begin
            unique case (cur_state)
                FETCH: begin
                    if (run) cur_state <= DECODE;
                end
                DECODE: begin
                    if (cls.system) begin
                        cur_state <= HALT;
                    end else if (cls.illegal) begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                        cur_state <= HALT;
`else
                        cur_state <= EXEC;
`endif
                    end else begin
                        cur_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (has_mem)      cur_state <= MEM;
                    else if (has_wb)  cur_state <= WB;
                    else              cur_state <= FETCH;
                end
                MEM: begin
                    if (cls.load) cur_state <= WB;
                    else          cur_state <= FETCH;
                end
                WB:      cur_state <= FETCH;
                HALT:    cur_state <= HALT;
                default: cur_state <= FETCH;
            endcase
        end
    end

    assign state = cur_state;

    // Last state of the current instruction; anything without a later
    // phase (including an unexpected class reaching EXEC) retires here
    always_comb begin
        last = 1'b0;
        unique case (cur_state)
            EXEC:    last = !has_mem && !has_wb;
            MEM:     last = !cls.load;
            WB:      last = 1'b1;
            default: last = 1'b0;
        endcase
    end

    // Datapath controls decoded from state and instruction class
    always_comb begin
        sub          = 1'b0;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        ULA_din2_sel = 1'b0;
        load_pc      = 1'b0;
        reset_pc     = RST;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        RF_din_sel   = RF_SEL_MEM;
        instr_done   = 1'b0;
        halted       = (cur_state == HALT);

        unique case (cur_state)
            EXEC: begin
                if (cls.r_type) begin
                    sub = alu_sub;
                end
                if (cls.i_alu || cls.load || cls.store) begin
                    ULA_din2_sel = 1'b1;
                end
                if (cls.branch) begin
                    sub = 1'b1;
                end
                if (cls.jal || cls.jalr) begin
                    WE_RF        = 1'b1;
                    RF_din_sel   = RF_SEL_PC4;
                    pc_adder_sel = cls.jalr;
                end
            end
            MEM: begin
                ULA_din2_sel = 1'b1;
                WE_MEM       = cls.store;
            end
            WB: begin
                if (cls.r_type) begin
                    sub        = alu_sub;
                    WE_RF      = 1'b1;
                    RF_din_sel = RF_SEL_ULA;
                end
                if (cls.i_alu) begin
                    ULA_din2_sel = 1'b1;
                    WE_RF        = 1'b1;
                    RF_din_sel   = RF_SEL_ULA;
                end
                if (cls.load) begin
                    ULA_din2_sel = 1'b1;
                    WE_RF        = 1'b1;
                    RF_din_sel   = RF_SEL_MEM;
                end
                if (cls.auipc) begin
                    WE_RF      = 1'b1;
                    RF_din_sel = RF_SEL_PC_IMM;
                end
            end
            default: begin
            end
        endcase

        // Single PC update per instruction, at retirement
        if (last) begin
            instr_done  = 1'b1;
            load_pc     = 1'b1;
            pc_next_sel = (cur_state == EXEC) && is_jump;
        end

        // Reset suppresses every architectural side effect
        if (RST) begin
            WE_RF   = 1'b0;
            WE_MEM  = 1'b0;
            load_pc = 1'b0;
        end
    end

endmodule
